// File: rtl/exception_ctrl.sv
// Interrupt/illegal-opcode sequencer for the 5-stage MIPS pipeline: flush, redirect, EPC/cause, eret guard.
// Define IRQ_RR_EN for round-robin IRQ arbitration; otherwise the lowest IRQ index wins.
module exception_ctrl #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h80000004,
  parameter logic [31:0] ILLOP_ADDR   = 32'h80000008
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               illop,
  input  logic [31:0]        id_pc,
  input  logic [31:0]        ex_pc,
  input  logic               ex_valid,
  input  logic               stall,
  input  logic               eret,
  output logic               flush_if,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic [31:0]        epc,
  output logic [7:0]         cause,
  output logic               kern_err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_GUARD   = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] req_pad;
  logic [7:0] ack_pad;
  logic [2:0] grant_idx;
  logic       grant_any;
  logic       user_ok;
  logic       take_illop;
  logic       take_irq;
  logic       do_eret;

  assign state   = state_q;
  assign req_pad = 8'(irq_req);
  assign irq_ack = ack_pad[NUM_IRQ-1:0];

  // A real user-mode instruction that is allowed to move this cycle.
  assign user_ok = ex_valid && !ex_pc[31] && !stall;

`ifdef IRQ_RR_EN
  logic [2:0] rr_ptr;

  always_comb begin
    logic [3:0] sum;
    sum       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      sum = {1'b0, rr_ptr} + 4'(i);
      if (sum >= 4'(NUM_IRQ)) sum = sum - 4'(NUM_IRQ);
      if (!grant_any && req_pad[sum[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[2:0];
      end
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!grant_any && req_pad[i]) begin
        grant_any = 1'b1;
        grant_idx = 3'(i);
      end
    end
  end
`endif

  // Take/eret decisions are Mealy: they act in the same cycle the condition is seen.
  always_comb begin
    take_illop = 1'b0;
    take_irq   = 1'b0;
    do_eret    = 1'b0;
    if (reset) begin
      case (state_q)
        ST_RUN: begin
          if (illop && !stall)          take_illop = 1'b1;
          else if (grant_any && user_ok) take_irq   = 1'b1;
        end
        ST_HANDLER: begin
          if (eret && !stall) do_eret = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    flush_if    = take_illop | take_irq | do_eret;
    flush_id    = take_illop | take_irq | do_eret;
    flush_ex    = take_irq;
    pc_redirect = take_illop | take_irq | do_eret;
    pc_target   = '0;
    if (take_illop)    pc_target = ILLOP_ADDR;
    else if (take_irq) pc_target = HANDLER_ADDR;
    else if (do_eret)  pc_target = epc;
    ack_pad = take_irq ? (8'b1 << grant_idx) : 8'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      epc      <= '0;
      cause    <= '0;
      kern_err <= 1'b0;
`ifdef IRQ_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (take_illop) begin
            epc     <= id_pc + 32'd4;
            cause   <= 8'h80;
            state_q <= ST_HANDLER;
          end else if (take_irq) begin
            epc     <= ex_pc;
            cause   <= {5'b0, grant_idx};
            state_q <= ST_HANDLER;
`ifdef IRQ_RR_EN
            rr_ptr  <= (grant_idx == 3'(NUM_IRQ - 1)) ? 3'd0 : grant_idx + 3'd1;
`endif
          end
        end
        ST_HANDLER: begin
          if (illop)   kern_err <= 1'b1;
          if (do_eret) state_q  <= ST_GUARD;
        end
        ST_GUARD: begin
          if (user_ok) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: comb outputs checked in-cycle, EPC/cause/state via expected queue.
module tb_exception_ctrl;
  localparam int          NUM_IRQ = 4;
  localparam logic [31:0] H_ADDR  = 32'h80000004;
  localparam logic [31:0] I_ADDR  = 32'h80000008;
  localparam logic [1:0]  S_RUN   = 2'd0;
  localparam logic [1:0]  S_HND   = 2'd1;
  localparam logic [1:0]  S_GRD   = 2'd2;

  logic               clk;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               illop;
  logic [31:0]        id_pc;
  logic [31:0]        ex_pc;
  logic               ex_valid;
  logic               stall;
  logic               eret;
  logic               flush_if, flush_id, flush_ex, pc_redirect;
  logic [31:0]        pc_target;
  logic [31:0]        epc;
  logic [7:0]         cause;
  logic               kern_err;
  logic [1:0]         state;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];  // {epc, cause, state} expected after the next edge

  exception_ctrl #(
    .NUM_IRQ(NUM_IRQ), .HANDLER_ADDR(H_ADDR), .ILLOP_ADDR(I_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_ack(irq_ack),
    .illop(illop), .id_pc(id_pc), .ex_pc(ex_pc), .ex_valid(ex_valid),
    .stall(stall), .eret(eret), .flush_if(flush_if), .flush_id(flush_id),
    .flush_ex(flush_ex), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .epc(epc), .cause(cause), .kern_err(kern_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // fl = {flush_if, flush_id, flush_ex, pc_redirect}
  task automatic check_out(input string tag, input logic [3:0] ack, input logic [3:0] fl,
                           input logic [31:0] tgt);
    check({tag, "_ack"}, 64'(irq_ack), 64'(ack));
    check({tag, "_flush"}, 64'({flush_if, flush_id, flush_ex, pc_redirect}), 64'(fl));
    check({tag, "_target"}, 64'(pc_target), 64'(tgt));
  endtask

  task automatic tick();
    logic [41:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_epc", 64'(epc), 64'(e[41:10]));
      check("sb_cause", 64'(cause), 64'(e[9:2]));
      check("sb_state", 64'(state), 64'(e[1:0]));
    end
  endtask

  task automatic take_irq(input logic [3:0] req, input logic [31:0] pc, input int g);
    irq_req = req; ex_valid = 1'b1; ex_pc = pc; stall = 1'b0; illop = 1'b0; eret = 1'b0;
    #1;
    check_out("take", 4'(1 << g), 4'b1111, H_ADDR);
    exp_q.push_back({pc, 8'(g), S_HND});
    tick();
  endtask

  task automatic do_eret(input logic [31:0] e, input logic [7:0] c);
    eret = 1'b1; stall = 1'b0; illop = 1'b0;
    #1;
    check_out("eret", 4'b0, 4'b1101, e);
    exp_q.push_back({e, c, S_GRD});
    tick();
    eret = 1'b0;
  endtask

  task automatic leave_guard(input logic [31:0] pc, input logic [31:0] e, input logic [7:0] c);
    ex_valid = 1'b1; ex_pc = pc; stall = 1'b0; illop = 1'b0; eret = 1'b0;
    #1;
    check_out("guard_exit", 4'b0, 4'b0, 32'b0);
    exp_q.push_back({e, c, S_RUN});
    tick();
  endtask

  task automatic idle_check(input string tag, input logic [1:0] exp_state);
    #1;
    check_out(tag, 4'b0, 4'b0, 32'b0);
    tick();
    check({tag, "_state"}, 64'(state), 64'(exp_state));
  endtask

  initial begin
    int rr_g [3];
    logic [31:0] pc;
    reset = 1'b0; irq_req = 4'hF; illop = 1'b0; id_pc = '0; ex_pc = 32'h10;
    ex_valid = 1'b1; stall = 1'b0; eret = 1'b0;

    // Reset held with every request asserted.
    repeat (3) begin
      tick();
      #1;
      check_out("rst", 4'b0, 4'b0, 32'b0);
      check("rst_state", 64'(state), 64'(S_RUN));
      check("rst_epc", 64'(epc), 64'd0);
      check("rst_cause", 64'(cause), 64'd0);
      check("rst_kern", 64'(kern_err), 64'd0);
    end
    reset = 1'b1;
    take_irq(4'hF, 32'h10, 0);

    // Handler ignores IRQs; stalled eret waits.
    for (int i = 0; i < 10; i++) idle_check("hnd_irq", S_HND);
    eret = 1'b1; stall = 1'b1;
    idle_check("eret_stall", S_HND);
    idle_check("eret_stall", S_HND);
    irq_req = 4'b0001;
    do_eret(32'h10, 8'h00);

    // Guard holds on kernel PC and bubbles, then re-take the cycle after exit.
    ex_valid = 1'b1; ex_pc = 32'h80000010;
    idle_check("guard_kpc", S_GRD);
    ex_valid = 1'b0; ex_pc = 32'h14;
    idle_check("guard_bub", S_GRD);
    leave_guard(32'h14, 32'h10, 8'h00);
    take_irq(4'b0001, 32'h14, 0);
    irq_req = 4'b0;
    do_eret(32'h14, 8'h00);
    leave_guard(32'h1c, 32'h14, 8'h00);

    // Illop beats a simultaneous IRQ.
    illop = 1'b1; id_pc = 32'h20; irq_req = 4'b0010; ex_pc = 32'h30; ex_valid = 1'b1;
    #1;
    check_out("illop", 4'b0, 4'b1101, I_ADDR);
    exp_q.push_back({32'h24, 8'h80, S_HND});
    tick();
    illop = 1'b0; irq_req = 4'b0;
    check("kern_before", 64'(kern_err), 64'd0);
    illop = 1'b1;
    idle_check("kern_illop", S_HND);
    illop = 1'b0;
    check("kern_set", 64'(kern_err), 64'd1);
    do_eret(32'h24, 8'h80);
    leave_guard(32'h40, 32'h24, 8'h80);

    // Illop left the arbiter pointer where the first IRQ take put it.
`ifdef IRQ_RR_EN
    take_irq(4'b0011, 32'h44, 1);
    do_eret(32'h44, 8'h01);
    leave_guard(32'h48, 32'h44, 8'h01);
`else
    take_irq(4'b0011, 32'h44, 0);
    do_eret(32'h44, 8'h00);
    leave_guard(32'h48, 32'h44, 8'h00);
`endif
    irq_req = 4'b0;

    // id_pc + 4 wraps.
    illop = 1'b1; id_pc = 32'hFFFFFFFC;
    #1;
    check_out("illop_wrap", 4'b0, 4'b1101, I_ADDR);
    exp_q.push_back({32'h0, 8'h80, S_HND});
    tick();
    illop = 1'b0;
    check("kern_sticky", 64'(kern_err), 64'd1);
    do_eret(32'h0, 8'h80);
    leave_guard(32'h50, 32'h0, 8'h80);

    // Stall defers an IRQ take; kernel PC, bubbles and eret in RUN never take.
    irq_req = 4'b0001; ex_pc = 32'h60; ex_valid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) idle_check("run_stall", S_RUN);
    take_irq(4'b0001, 32'h60, 0);
    do_eret(32'h60, 8'h00);
    leave_guard(32'h64, 32'h60, 8'h00);
    irq_req = 4'b0001; ex_pc = 32'h80000100;
    idle_check("run_kpc", S_RUN);
    ex_pc = 32'h60; ex_valid = 1'b0;
    idle_check("run_bub", S_RUN);
    irq_req = 4'b0; ex_valid = 1'b1; eret = 1'b1;
    idle_check("run_eret", S_RUN);
    eret = 1'b0;

    // Randomised user PCs and guard hold lengths.
    for (int r = 0; r < 4; r++) begin
      pc = {1'b0, 29'($urandom_range(1, 32'h0FFFFFFF)), 2'b00};
      take_irq(4'b0001, pc, 0);
      irq_req = 4'b0;
      do_eret(pc, 8'h00);
      ex_pc = 32'h80000000 | pc; ex_valid = 1'b1;
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) idle_check("rnd_guard", S_GRD);
      leave_guard(pc + 32'd4, pc, 8'h00);
    end

    // Fresh reset, then three rounds with two lines held.
    reset = 1'b0;
    tick();
    #1;
    check_out("rst2", 4'b0, 4'b0, 32'b0);
    check("rst2_state", 64'(state), 64'(S_RUN));
    check("rst2_epc", 64'(epc), 64'd0);
    check("rst2_kern", 64'(kern_err), 64'd0);
    reset = 1'b1;
`ifdef IRQ_RR_EN
    rr_g = '{0, 1, 0};
`else
    rr_g = '{0, 0, 0};
`endif
    for (int r = 0; r < 3; r++) begin
      pc = 32'h100 + 32'(r * 16);
      take_irq(4'b0011, pc, rr_g[r]);
      do_eret(pc, 8'(rr_g[r]));
      leave_guard(pc + 32'd4, pc, 8'(rr_g[r]));
    end

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
